// File: rtl/pipe_stage_pkg.sv
// Shared definitions for the generic pipeline-stage register.
// Holds the FSM state encoding, the per-stage bundle widths and the
// bubble (NOP) payloads for each inter-stage register.
// Optional feature macro used by the stage: PIPE_STAGE_SKID_EN.
package pipe_stage_pkg;

    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'd0,
        PIPE_BUSY  = 2'd1,
        PIPE_FULL  = 2'd2
    } pipe_state_e;

    // Core-wide encodings the NOP bundles are assembled from.
    localparam logic [7:0]  EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [2:0]  EXE_RES_NOP  = 3'b000;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr   = 5'b00000;
    localparam logic        WriteDisable = 1'b0;

    // IF/ID: pc + instruction.
    localparam int unsigned IF_ID_W = 64;
    localparam logic [IF_ID_W-1:0] IF_ID_NOP = {ZeroWord, ZeroWord};

    // ID/EX: aluop, alusel, reg1, reg2, wd, wreg.
    localparam int unsigned ID_EX_W = 81;
    localparam logic [ID_EX_W-1:0] ID_EX_NOP =
        {EXE_NOP_OP, EXE_RES_NOP, ZeroWord, ZeroWord, NOPRegAddr, WriteDisable};

    // EX/MEM and MEM/WB: wd, wreg, wdata.
    localparam int unsigned EX_MEM_W = 38;
    localparam logic [EX_MEM_W-1:0] EX_MEM_NOP = {NOPRegAddr, WriteDisable, ZeroWord};

    localparam int unsigned MEM_WB_W = 38;
    localparam logic [MEM_WB_W-1:0] MEM_WB_NOP = {NOPRegAddr, WriteDisable, ZeroWord};

endpackage

// File: rtl/pipe_stage_ctrl.sv
// Handshake FSM for pipe_stage_reg.
// Ports: clk/rst (async active-high), flush, in_valid/in_ready,
// out_valid/out_ready, occupancy, and payload strobes load_main,
// load_skid/main_from_skid (PIPE_STAGE_SKID_EN builds only) and clear.
//
// state      | meaning
// PIPE_EMPTY | no entry held, out_data is the bubble
// PIPE_BUSY  | one entry in main
// PIPE_FULL  | main and skid both hold entries (skid build only)
module pipe_stage_ctrl
    import pipe_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] occupancy,
    output logic       load_main,
`ifdef PIPE_STAGE_SKID_EN
    output logic       load_skid,
    output logic       main_from_skid,
`endif
    output logic       clear
);

    pipe_state_e state_q, state_d;
    logic        in_fire, out_fire;

    assign out_valid = (state_q != PIPE_EMPTY);
    assign occupancy = state_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
    // Registered from the next state so upstream never sees out_ready.
    logic in_ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) in_ready_q <= 1'b1;
        else     in_ready_q <= (state_d != PIPE_FULL);
    end

    assign in_ready = in_ready_q;
`else
    assign in_ready = !out_valid || out_ready;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= PIPE_EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        clear     = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
`endif
        if (flush) begin
            state_d = PIPE_EMPTY;
            clear   = 1'b1;
        end else begin
            case (state_q)
                PIPE_EMPTY: begin
                    if (in_fire) begin
                        state_d   = PIPE_BUSY;
                        load_main = 1'b1;
                    end
                end
                PIPE_BUSY: begin
                    if (in_fire && out_fire) begin
                        load_main = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (in_fire) begin
                        state_d   = PIPE_FULL;
                        load_skid = 1'b1;
`endif
                    end else if (out_fire) begin
                        // Skid is already the bubble outside FULL, so a full clear is safe.
                        state_d = PIPE_EMPTY;
                        clear   = 1'b1;
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                PIPE_FULL: begin
                    if (out_fire) begin
                        state_d        = PIPE_BUSY;
                        main_from_skid = 1'b1;
                    end
                end
`endif
                default: state_d = PIPE_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage register with valid/ready handshake, flush and
// bubble insertion. Carries an arbitrary packed payload.
// Ports: clk, rst (async active-high), flush, in_valid/in_ready/in_data,
// out_valid/out_ready/out_data, occupancy (0..2).
// Macro PIPE_STAGE_SKID_EN adds a skid register and registers in_ready;
// without it the stage holds one entry and in_ready depends on out_ready.
module pipe_stage_reg
    import pipe_stage_pkg::*;
#(
    parameter int unsigned         DATA_W    = ID_EX_W,
    parameter logic [DATA_W-1:0]   NOP_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              load_main, clear;
    logic [DATA_W-1:0] main_q;

`ifdef PIPE_STAGE_SKID_EN
    logic              load_skid, main_from_skid;
    logic [DATA_W-1:0] skid_q;
`endif

    pipe_stage_ctrl u_ctrl (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .occupancy      (occupancy),
        .load_main      (load_main),
`ifdef PIPE_STAGE_SKID_EN
        .load_skid      (load_skid),
        .main_from_skid (main_from_skid),
`endif
        .clear          (clear)
    );

`ifdef PIPE_STAGE_SKID_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= NOP_VALUE;
            skid_q <= NOP_VALUE;
        end else if (clear) begin
            main_q <= NOP_VALUE;
            skid_q <= NOP_VALUE;
        end else if (load_main) begin
            main_q <= in_data;
        end else if (main_from_skid) begin
            main_q <= skid_q;
            skid_q <= NOP_VALUE;
        end else if (load_skid) begin
            skid_q <= in_data;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            main_q <= NOP_VALUE;
        else if (clear)     main_q <= NOP_VALUE;
        else if (load_main) main_q <= in_data;
    end
`endif

    // Main is forced to the bubble whenever the stage is empty.
    assign out_data = main_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam int W = 81;
    localparam logic [W-1:0] NOP = '0;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [W-1:0] mq[$];    // model: entries held, oldest first
    logic [W-1:0] mon[$];   // entries the downstream actually took from the DUT

    pipe_stage_reg dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else             pass_cnt++;
    endtask

    function automatic logic model_in_ready();
        if (CAP == 2) return mq.size() < 2;
        return (mq.size() == 0) || out_ready;
    endfunction

    // Queue model: a stage is a FIFO of capacity CAP with flush.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
        end else begin
            logic in_f, out_f;
            in_f  = in_valid && model_in_ready();
            out_f = (mq.size() > 0) && out_ready;
            if (flush) begin
                mq.delete();
            end else begin
                if (out_f) void'(mq.pop_front());
                if (in_f) mq.push_back(in_data);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("out_valid", W'(out_valid), W'(mq.size() > 0));
            check("out_data",  out_data, (mq.size() > 0) ? mq[0] : NOP);
            check("occupancy", W'(occupancy), W'(mq.size()));
            check("in_ready",  W'(in_ready), W'(model_in_ready()));
            if (out_valid && out_ready) mon.push_back(out_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] mon_at(input int i);
        if (i < mon.size()) return mon[i];
        return {W{1'b1}};
    endfunction

    initial begin
        repeat (3) step();
        rst = 1'b0;
        step();
        check("rst_valid", W'(out_valid), W'(0));
        check("rst_occ",   W'(occupancy), W'(0));
        check("rst_ready", W'(in_ready),  W'(1));
        check("rst_data",  out_data, NOP);

        // Streaming at full rate
        mon.delete();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = W'(i);
            step();
            check("stream_lat", out_data, W'(i));
        end
        in_valid = 1'b0;
        repeat (2) step();
        check("stream_cnt", W'(mon.size()), W'(4));
        for (int i = 0; i < 4; i++) check("stream_ord", mon_at(i), W'(i + 1));

        // Backpressure
        mon.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = W'(81'hA);
        step();
        check("bp_occ1", W'(occupancy), W'(1));
`ifdef PIPE_STAGE_SKID_EN
        in_data = W'(81'hB);
        step();
        check("bp_occ2",   W'(occupancy), W'(2));
        check("bp_rdy0",   W'(in_ready),  W'(0));
        in_valid = 1'b0;
        step();
        out_ready = 1'b1;
        step();
        check("bp_rdy1",   W'(in_ready), W'(1));
        check("bp_dataB",  out_data, W'(81'hB));
        step();
        check("bp_cnt",    W'(mon.size()), W'(2));
        check("bp_first",  mon_at(0), W'(81'hA));
        check("bp_second", mon_at(1), W'(81'hB));
`else
        check("ns_rdy0", W'(in_ready), W'(0));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("ns_rdy1_comb", W'(in_ready), W'(1));
        step();
        check("ns_cnt",   W'(mon.size()), W'(1));
        check("ns_first", mon_at(0), W'(81'hA));
`endif

        // Flush with an entry arriving in the same cycle
        mon.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = W'(81'hD);
        step();
`ifdef PIPE_STAGE_SKID_EN
        in_data = W'(81'hE);
        step();
        check("fl_full", W'(occupancy), W'(2));
`endif
        in_data = W'(81'hC);
        flush   = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", W'(out_valid), W'(0));
        check("fl_occ",   W'(occupancy), W'(0));
        check("fl_data",  out_data, NOP);
        out_ready = 1'b1;
        repeat (3) step();
        check("fl_none", W'(mon.size()), W'(0));

        // Flush concurrent with delivery
        mon.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = W'(81'h55);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b1;
        step();
        flush = 1'b0;
        repeat (3) step();
        check("flo_cnt", W'(mon.size()), W'(1));
        check("flo_val", mon_at(0), W'(81'h55));

        // Asynchronous reset while BUSY
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = W'(81'h1_2345_6789);
        step();
        in_valid = 1'b0;
        check("ar_pre", out_data, W'(81'h1_2345_6789));
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid", W'(out_valid), W'(0));
        check("ar_data",  out_data, NOP);
        check("ar_occ",   W'(occupancy), W'(0));
        step();
        rst = 1'b0;
        repeat (2) step();
        check("ar_after", W'(out_valid), W'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-stage register with a valid/ready handshake, synchronous flush and bubble insertion. It replaces the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block that carries an arbitrary-width packed payload. It lets a stage stall without losing data and lets the control unit squash in-flight instructions. An optional skid buffer fully registers the upstream ready path.

## Interface
- DATA_W, 81, packed payload width; default is the ID/EX bundle: aluop 8 + alusel 3 + reg1 32 + reg2 32 + wd 5 + wreg 1.
- NOP_VALUE, 0, payload driven on out_data while the stage holds no valid entry (bubble). The ID/EX bundle must encode NOP op, NOP sel, zero operands, NOP reg addr and write disable.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  reset, asynchronous, active-high (1 = RstEnable).
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  downstream payload valid.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  downstream payload; NOP_VALUE when out_valid=0.
- occupancy  out  2  number of held entries (0..2; max 1 without skid).

## Operation
- A transfer is in_fire = in_valid & in_ready, or out_fire = out_valid & out_ready.
- Payload is never modified, reordered or duplicated. Entries leave in arrival order.
- FSM with skid (states EMPTY, BUSY, FULL; main and skid registers):
  - EMPTY: in_fire -> BUSY, main <= in_data.
  - BUSY, in_fire & out_fire: stay BUSY, main <= in_data.
  - BUSY, in_fire & !out_fire: -> FULL, skid <= in_data.
  - BUSY, !in_fire & out_fire: -> EMPTY, main <= NOP_VALUE.
  - BUSY, otherwise: hold.
  - FULL: out_fire -> BUSY, main <= skid, skid <= NOP_VALUE. Otherwise hold. in_fire is impossible because in_ready=0.
- in_ready is a registered output, equal to (state != FULL) as of the current state.
- out_valid = (state != EMPTY). out_data = main.
- Flush has priority over every transition. Next state is EMPTY and main, skid <= NOP_VALUE.
  - An in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle counts as delivered; the downstream sampled it.
- in_valid may be withdrawn freely while in_ready=0. Once out_valid=1, out_data must stay stable until out_fire or flush.
- occupancy: EMPTY=0, BUSY=1, FULL=2.

## Timing
- Reset (asynchronous assert, effective immediately):
  - out_valid=0, out_data=NOP_VALUE, occupancy=0, in_ready=1 (skid build).
  - State EMPTY. Skid register = NOP_VALUE.
- Release takes effect at the first posedge after rst falls.
- Latency: in_fire at edge N puts the payload on out_data after edge N, with out_valid=1 in cycle N+1.
- Throughput: 1 entry per cycle when out_ready is held at 1.
- Stall: out_ready=0 in BUSY absorbs one more entry, then in_ready drops one cycle later.
- Reset mid-operation discards all entries with no partial output.

## Configuration
- Macro PIPE_STAGE_SKID_EN.
- Defined: two-entry skid implementation as above. in_ready is registered and has no combinational path from out_ready.
- Undefined: single main register, states EMPTY/BUSY only.
  - in_ready = !out_valid | out_ready, a combinational path.
  - BUSY with in_fire & out_fire reloads main.
  - FULL is unreachable and occupancy never exceeds 1.
  - Flush and reset behaviour are unchanged.

## Structure
- Shared package/defines header holds:
  - State encodings PIPE_EMPTY=2'd0, PIPE_BUSY=2'd1, PIPE_FULL=2'd2.
  - Constant ID_EX_W=81 and the ID/EX NOP payload constant, built from the existing EXE_NOP_OP, EXE_RES_NOP, ZeroWord, NOPRegAddr and WriteDisable defines.
  - Corresponding widths and NOP constants for the other stage bundles.
- Sub-module pipe_stage_ctrl contains the FSM, in_ready, out_valid and occupancy, and emits load_main, load_skid, main_from_skid and clear strobes.
- The payload registers stay in pipe_stage_reg.

## Test plan
- Reset while BUSY with out_data=0x1_2345_6789: out_valid drops to 0 and out_data=NOP_VALUE immediately, with no clock edge; occupancy=0.
- Streaming: out_ready=1, in_valid=1, in_data=1,2,3,4 on consecutive edges -> out_data shows 1,2,3,4 one cycle later, with no gaps.
- Backpressure (skid build): send A, B with out_ready=0 -> occupancy 1 then 2, in_ready=0 the cycle after B is taken. Raise out_ready -> A then B delivered in order, and in_ready returns to 1 one cycle after A leaves.
- Flush while FULL, with in_valid=1 carrying C -> next cycle out_valid=0, occupancy=0, out_data=NOP_VALUE. C is never output.
- Flush concurrent with out_fire of A in BUSY -> A counted once by the downstream monitor and nothing else emitted.
- Non-skid build (PIPE_STAGE_SKID_EN undefined): with out_ready=0 in BUSY, in_ready=0 in the same cycle. Toggling out_ready to 1 raises in_ready combinationally in that cycle.
